// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit: size encodings,
// FSM state type, captured-request payload and beat helpers.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ACC_W  = DATA_W - BYTE_W;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Request fields held for the whole transaction (address kept separately,
  // its width is a top-level parameter).
  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic              sgn;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Number of byte beats for a transfer size.
  function automatic logic [CNT_W-1:0] beats(input logic [1:0] size);
    case (size)
      SZ_BYTE: beats = CNT_W'(1);
      SZ_HALF: beats = CNT_W'(2);
      default: beats = CNT_W'(4);
    endcase
  endfunction

  // Store byte for beat 'cnt': most significant byte of the sized field first.
  function automatic logic [BYTE_W-1:0] store_byte(input logic [DATA_W-1:0] wdata,
                                                   input logic [1:0]        size,
                                                   input logic [CNT_W-1:0]  cnt);
    logic [CNT_W-1:0] idx;
    idx = beats(size) - cnt - CNT_W'(1);
    case (idx)
      3'd0:    store_byte = wdata[7:0];
      3'd1:    store_byte = wdata[15:8];
      3'd2:    store_byte = wdata[23:16];
      default: store_byte = wdata[31:24];
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational sign/zero extension of an assembled load value.
// Ports: acc   - assembled bytes, last byte in [7:0]
//        size  - transfer size (byte/half extended, word passed through)
//        sgn   - 1 = sign-extend, 0 = zero-extend
//        ext_c - extended result
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] acc,
  input  logic [1:0]        size,
  input  logic              sgn,
  output logic [DATA_W-1:0] ext_c
);

  always_comb begin
    ext_c = acc;
    case (size)
      SZ_BYTE: ext_c = {{24{sgn & acc[7]}}, acc[7:0]};
      SZ_HALF: ext_c = {{16{sgn & acc[15]}}, acc[15:0]};
      default: ext_c = acc;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial, big-endian load/store initiator. Accepts one byte/half/word
// request in IDLE, issues one memory byte beat per cycle (MSB first), then
// pulses rspValid with the extended load data or an error.
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned half/word.
// Ports: clk, rstN (sync, active-low)
//        req*  - request handshake and payload from the memory stage
//        rsp*  - one-cycle completion with load data / error
//        mem*  - byte-wide memory port; memRData is combinational
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
)
(
  input  logic              clk,
  input  logic              rstN,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [1:0]        reqSize,
  input  logic              reqSigned,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [31:0]       reqWData,
  output logic              rspValid,
  output logic [31:0]       rspRData,
  output logic              rspError,
  output logic [ADDR_W-1:0] memAddr,
  output logic [7:0]        memWData,
  output logic              memRead,
  output logic              memWrite,
  input  logic [7:0]        memRData
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  req_t               req_q, req_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;

  logic               ready_d, rsp_valid_d, rsp_error_d, mem_read_d, mem_write_d;
  logic [DATA_W-1:0]  rsp_rdata_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [BYTE_W-1:0]  mem_wdata_d;

  logic [DATA_W-1:0]  acc_shift;
  logic [DATA_W-1:0]  ext_c;
  logic               req_bad;
  logic               last_beat;

  // Accumulator with the byte currently on the read port appended.
  assign acc_shift = {acc_q, memRData};
  assign last_beat = (cnt_q == (beats(req_q.size) - CNT_W'(1)));

  // Request legality.
`ifdef LSU_ALIGN_CHECK_EN
  assign req_bad = (reqSize == SZ_RSVD) ||
                   ((reqSize == SZ_HALF) && reqAddr[0]) ||
                   ((reqSize == SZ_WORD) && (reqAddr[1:0] != 2'b00));
`else
  assign req_bad = (reqSize == SZ_RSVD);
`endif

  lsu_extend u_extend (
    .acc   (acc_shift),
    .size  (req_q.size),
    .sgn   (req_q.sgn),
    .ext_c (ext_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_error_d = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (reqReady && reqValid) begin
          ready_d = 1'b0;
          addr_d  = reqAddr;
          req_d   = '{write: reqWrite, size: reqSize, sgn: reqSigned, wdata: reqWData};
          cnt_d   = '0;
          acc_d   = '0;
          if (req_bad) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            state_d     = ACCESS;
            mem_addr_d  = reqAddr;
            mem_read_d  = ~reqWrite;
            mem_write_d = reqWrite;
            mem_wdata_d = reqWrite ? store_byte(reqWData, reqSize, '0) : '0;
          end
        end
      end

      ACCESS: begin
        if (!req_q.write) begin
          acc_d = acc_shift[ACC_W-1:0];
        end
        if (last_beat) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = req_q.write ? '0 : ext_c;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          mem_addr_d  = addr_q + ADDR_W'(cnt_d);
          mem_read_d  = ~req_q.write;
          mem_write_d = req_q.write;
          mem_wdata_d = req_q.write ? store_byte(req_q.wdata, req_q.size, cnt_d) : '0;
        end
      end

      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      req_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      reqReady <= 1'b0;
      rspValid <= 1'b0;
      rspRData <= '0;
      rspError <= 1'b0;
      memAddr  <= '0;
      memWData <= '0;
      memRead  <= 1'b0;
      memWrite <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      reqReady <= ready_d;
      rspValid <= rsp_valid_d;
      rspRData <= rsp_rdata_d;
      rspError <= rsp_error_d;
      memAddr  <= mem_addr_d;
      memWData <= mem_wdata_d;
      memRead  <= mem_read_d;
      memWrite <= mem_write_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected beats and
// responses; negedge monitors pop and compare whenever the DUT shows them.
module tb_load_store_unit;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic              reqValid = 1'b0;
  logic              reqReady;
  logic              reqWrite = 1'b0;
  logic [1:0]        reqSize = 2'b00;
  logic              reqSigned = 1'b0;
  logic [ADDR_W-1:0] reqAddr = '0;
  logic [31:0]       reqWData = '0;
  logic              rspValid;
  logic [31:0]       rspRData;
  logic              rspError;
  logic [ADDR_W-1:0] memAddr;
  logic [7:0]        memWData;
  logic              memRead;
  logic              memWrite;
  logic [7:0]        memRData;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstN(rstN),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqWData(reqWData),
    .rspValid(rspValid), .rspRData(rspRData), .rspError(rspError),
    .memAddr(memAddr), .memWData(memWData), .memRead(memRead), .memWrite(memWrite),
    .memRData(memRData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 1 KiB memory aliased on address bits [9:0]; combinational read.
  logic [7:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
  always @(posedge clk) if (memWrite) mem[memAddr[9:0]] <= memWData;
  assign memRData = mem[memAddr[9:0]];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  data;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  beat_t mb;
  rsp_t  mr;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory-beat monitor.
  always @(negedge clk) begin
    if (memRead || memWrite) begin
      check("beat_onehot", 32'(memRead & memWrite), 32'd0);
      if (beat_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_beat: addr 0x%08h rd %0b wr %0b, none expected (cycle %0d)",
                 memAddr, memRead, memWrite, cyc);
      end else begin
        mb = beat_q.pop_front();
        check("beat_write", 32'(memWrite), 32'(mb.wr));
        check("beat_addr", memAddr, mb.addr);
        check("beat_cycle", 32'(cyc), 32'(mb.cyc));
        if (mb.wr) check("beat_wdata", 32'(memWData), 32'(mb.data));
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rspValid) begin
      if (rsp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: rdata 0x%08h err %0b, none expected (cycle %0d)",
                 rspRData, rspError, cyc);
      end else begin
        mr = rsp_q.pop_front();
        check("rsp_rdata", rspRData, mr.rdata);
        check("rsp_error", 32'(rspError), 32'(mr.err));
        check("rsp_cycle", 32'(cyc), 32'(mr.cyc));
      end
    end
  end

  // Bounded wait for the unit to report ready; called at posedge+#1.
  task automatic wait_ready();
    int k = 0;
    while (!reqReady && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!reqReady) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: reqReady 0 expected 1 after %0d cycles", k);
    end
  endtask

  // Bounded wait for all expected beats/responses to be observed.
  task automatic drain();
    int k = 0;
    while ((beat_q.size() != 0 || rsp_q.size() != 0) && k < 40) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (beat_q.size() != 0 || rsp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats and %0d responses outstanding, expected 0",
               beat_q.size(), rsp_q.size());
      beat_q.delete();
      rsp_q.delete();
    end
  endtask

  // Issue one request with its hand-computed expected response. 'hold' keeps
  // reqValid asserted through that many busy cycles after acceptance.
  task automatic op(input logic wr, input logic [1:0] sz, input logic sg,
                    input logic [31:0] addr, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic exp_err, input int hold);
    int    n;
    int    c0;
    beat_t b;
    rsp_t  r;
    wait_ready();
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    reqValid  = 1'b1;
    reqWrite  = wr;
    reqSize   = sz;
    reqSigned = sg;
    reqAddr   = addr;
    reqWData  = wd;
    c0 = cyc + 1;
    if (exp_err) begin
      r = '{rdata: 32'h0, err: 1'b1, cyc: c0};
      rsp_q.push_back(r);
    end else begin
      for (int i = 0; i < n; i++) begin
        b.wr   = wr;
        b.addr = addr + 32'(i);
        b.data = 8'(wd >> (8 * (n - 1 - i)));
        b.cyc  = c0 + i;
        beat_q.push_back(b);
      end
      r = '{rdata: (wr ? 32'h0 : exp_rd), err: 1'b0, cyc: c0 + n};
      rsp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < hold; k++) begin
      check("ready_busy", 32'(reqReady), 32'd0);
      @(posedge clk);
      #1;
    end
    reqValid = 1'b0;
    drain();
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  initial begin
    int c0;
    beat_t b;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(reqReady), 32'd0);
    check("rst_rsp", {rspRData[31:2], rspValid, rspError}, 32'd0);
    check("rst_mem", {memAddr[31:10], memWData, memRead, memWrite}, 32'd0);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", 32'(reqReady), 32'd1);

    // Word store / load
    op(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    check("mem_word_100", mem_word(32'h100), 32'hDEADBEEF);
    op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Byte loads, signed and unsigned
    op(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'hFFFFFFAD, 1'b0, 0);
    op(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h000000AD, 1'b0, 0);

    // Half store / loads
    op(1'b1, 2'b01, 1'b0, 32'h200, 32'h12348001, 32'h0, 1'b0, 0);
    check("mem_half_200", {16'h0, mem[32'h200], mem[32'h201]}, 32'h00008001);
    op(1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 32'hFFFF8001, 1'b0, 0);
    op(1'b0, 2'b01, 1'b0, 32'h200, 32'h0, 32'h00008001, 1'b0, 0);

    // Misaligned word / half
`ifdef LSU_ALIGN_CHECK_EN
    op(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 0);
    op(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 32'h0, 1'b1, 0);
`else
    op(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'hBEEF0000, 1'b0, 0);
    op(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 32'hFFFFADBE, 1'b0, 0);
`endif

    // Reserved size: error, no beats, for load and store
    op(1'b0, 2'b11, 1'b1, 32'h100, 32'h0, 32'h0, 1'b1, 0);
    op(1'b1, 2'b11, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    check("mem_after_err", mem_word(32'h100), 32'hDEADBEEF);

    // reqValid held through ACCESS is ignored
    op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 4);

    // Byte store at an odd address, then read back
    op(1'b1, 2'b00, 1'b0, 32'h103, 32'hCAFE0077, 32'h0, 1'b0, 0);
    op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h00000077, 1'b0, 0);
    op(1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 32'hDEADBE77, 1'b0, 0);

    // Half store wrapping through the top of the address space
`ifdef LSU_ALIGN_CHECK_EN
    op(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0000C3A5, 32'h0, 1'b1, 0);
    check("wrap_untouched", {16'h0, mem[1023], mem[0]}, 32'h0);
`else
    op(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0000C3A5, 32'h0, 1'b0, 0);
    check("wrap_bytes", {16'h0, mem[1023], mem[0]}, 32'h0000C3A5);
`endif

    // Reset during beat 2 of a word store
    wait_ready();
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqSize  = 2'b10;
    reqSigned = 1'b0;
    reqAddr  = 32'h300;
    reqWData = 32'hA1B2C3D4;
    c0 = cyc + 1;
    b = '{wr: 1'b1, addr: 32'h300, data: 8'hA1, cyc: c0};
    beat_q.push_back(b);
    b = '{wr: 1'b1, addr: 32'h301, data: 8'hB2, cyc: c0 + 1};
    beat_q.push_back(b);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_memwrite", 32'(memWrite), 32'd0);
    check("rst_mid_ready", 32'(reqReady), 32'd0);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_ready_release", 32'(reqReady), 32'd1);
    check("rst_mid_mem", mem_word(32'h300), 32'hA1B20000);
    check("rst_mid_beats_seen", 32'(beat_q.size()), 32'd0);
    op(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'hA1B20000, 1'b0, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-serial load/store initiator that drives the processor's byte-addressed, big-endian data memory port. It takes one word, halfword or byte request at a time from the datapath and issues one byte beat per cycle. For loads it assembles and sign- or zero-extends the result; for stores it splits the data into bytes. It sits between the pipeline memory stage and the data memory, replacing direct 4-byte-wide access.

## Interface
- ADDR_W, 32, address width; all address arithmetic is modulo 2^ADDR_W.
- clk  in  1  rising-edge clock.
- rstN  in  1  synchronous, active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  unit can accept a request (high only in IDLE).
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  00 byte, 01 half, 10 word, 11 reserved.
- reqSigned  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
- reqAddr  in  ADDR_W  byte address of the most significant byte.
- reqWData  in  32  store data, right-aligned.
- rspValid  out  1  one-cycle completion pulse.
- rspRData  out  32  extended load data; 0 for stores and errors.
- rspError  out  1  request rejected; valid with rspValid.
- memAddr  out  ADDR_W  byte address of the current beat.
- memWData  out  8  byte to write.
- memRead  out  1  read beat.
- memWrite  out  1  write beat.
- memRData  in  8  byte returned combinationally in the same cycle as memAddr.

## Operation
- States:
  - IDLE: reqReady=1. When reqValid is high at an edge, capture addr, size, write, signed and wdata; set beat count to 0.
    - Invalid request: go to RESP with error set.
    - Valid request: go to ACCESS.
  - ACCESS: exactly one of memRead/memWrite is high. memAddr = base + count, with wrap-around.
    - Count increments each cycle.
    - After beat N-1, go to RESP. N = 1, 2 or 4 for byte, half or word.
  - RESP: rspValid=1 for one cycle, then go to IDLE.
- Invalid request: reqSize=11 always. Misalignment is also invalid when the alignment check is compiled in (see Configuration).
- Store byte order is MSB first:
  - word: beats carry wdata[31:24], [23:16], [15:8], [7:0].
  - half: beats carry wdata[15:8], [7:0].
  - byte: the single beat carries wdata[7:0].
- Load assembly: each beat shifts memRData into an accumulator from the LSB (acc = {acc[23:0], memRData}). In RESP, extend acc[7:0] or acc[15:0] per reqSigned; a word load passes through unchanged.
- Requests are never queued. reqValid while not in IDLE is ignored.
- Reset mid-operation:
  - Next edge forces IDLE and clears all outputs and the accumulator.
  - Bytes already written stay in memory; no rollback.
- Reset values: reqReady=0 while rstN low, 1 in the first cycle after release. rspValid, rspRData, rspError, memRead, memWrite, memAddr and memWData are all 0.

## Timing
- Accept at edge E0. Beats occur in cycles E0+1 .. E0+N. rspValid is high in cycle E0+N+1. The next accept is possible at the following edge.
- Throughput: one request per N+2 cycles.
- Error path: rspValid with rspError=1 in cycle E0+1; no memory beats.
- memRData is sampled at the edge closing each read beat.
- All memory-side outputs are registered; nothing reaches memRead/memWrite combinationally from req*.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - Halfword with addr[0]≠0 is rejected with rspError=1.
  - Word with addr[1:0]≠0 is rejected with rspError=1.
- LSU_ALIGN_CHECK_EN undefined:
  - Any address is accepted; beats wrap through address 2^ADDR_W−1 to 0.
  - rspError is high only for reqSize=11.

## Structure
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - state enum IDLE/ACCESS/RESP.
  - function beats(size) returning 1, 2 or 4.
- One sub-module, lsu_extend: combinational byte/half sign/zero extension of the accumulator.

## Test plan
- Word store 0xDEADBEEF at 0x100, then word load from 0x100 -> memory bytes 0x100..0x103 = DE AD BE EF; rspRData=0xDEADBEEF; rspValid 5 cycles after accept.
- Byte load from 0x101 after the above: signed -> 0xFFFFFFAD; unsigned -> 0x000000AD; rspValid 2 cycles after accept.
- Half store 0x12348001 at 0x200 -> bytes 0x200=0x80, 0x201=0x01. Signed half load from 0x200 -> 0xFFFF8001.
- Word load at 0x102:
  - with LSU_ALIGN_CHECK_EN: rspError=1 and no memRead pulses.
  - without it: 4 beats at 0x102..0x105.
- reqSize=11 -> rspError=1, rspRData=0, no memory beats. reqValid held during ACCESS is ignored, and reqReady=0 throughout ACCESS.
- rstN low during beat 2 of a word store -> next cycle memWrite=0, reqReady=0. After release, reqReady=1; bytes 0 and 1 are written, bytes 2 and 3 are untouched.
